uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
- Control FSM for the UART transmitter.
- Sequences one frame: start bit, data_width data bits from the serializer, optional parity bit from tx_parity_calc, stop bit.
- Drives the serializer enable/load, the parity-calc load strobe and the output-mux select.
- Sits between the host-side data_valid interface and the TX datapath (serializer, tx_parity_calc, output mux).

Parameters:
data_width, 8, number of data bits per frame; sizes the internal bit counter as $clog2(data_width)+1 bits.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
data_valid  input  1  host requests transmission of the word currently on the datapath p_data bus
par_en  input  1  1 = frame carries a parity bit; sampled only at accept
ser_done  input  1  serializer flag, high in the cycle it shifts out the last data bit
data_load  output  1  Mealy pulse; serializer and tx_parity_calc register p_data at the next edge
ser_en  output  1  serializer shift enable
mux_sel  output  2  00 start (0), 01 stop/idle (1), 10 serial data, 11 parity bit
busy  output  1  frame in progress
frame_err  output  1  one-cycle pulse: DATA phase timed out without ser_done

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, mux_sel=01, ser_en=0, busy=0, data_load=0, frame_err=0.
  - par_en_q=0, bit_cnt=0.
  - Effective immediately, including mid-frame; the line returns to idle high.
- State register is Moore. mux_sel, ser_en and busy decode from state only and are registered-state outputs. data_load is Mealy.
- IDLE:
  - mux_sel=01, busy=0.
  - data_valid=1 is an accept: data_load=1 in the same cycle, par_en_q<=par_en, next state START.
- START (1 cycle):
  - mux_sel=00, busy=1.
  - bit_cnt<=0, next state DATA.
- DATA:
  - mux_sel=10, ser_en=1, busy=1.
  - bit_cnt increments each cycle.
  - On ser_done=1: next state PARITY if par_en_q, else STOP.
  - Timeout: if bit_cnt==data_width-1 and ser_done=0, frame_err pulses next cycle and the FSM proceeds as if ser_done were seen. DATA never exceeds data_width cycles.
- PARITY (1 cycle): mux_sel=11, busy=1, next state STOP.
- STOP (1 cycle):
  - mux_sel=01, busy=1.
  - data_valid=1: accept (data_load=1, par_en_q<=par_en), next state START. Back-to-back frames, no idle gap.
  - data_valid=0: next state IDLE.
- data_valid is ignored in START, DATA and PARITY; no queuing, and the host must hold it or retry.
- par_en changes outside an accept cycle have no effect on the current frame.
- Frame length:
  - 1 + data_width + 1 cycles without parity (10 at default).
  - 1 + data_width + 2 cycles with parity (11 at default).
  - busy is high for exactly that many cycles per frame.
- ser_done arriving early (before data_width cycles) is honoured; DATA ends that cycle. ser_done outside DATA is ignored.
- Simultaneous ser_done and timeout in the same cycle: treated as normal completion, frame_err=0.

Decomposition:
- Shared package uart_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - mux-select constants MUX_START=2'b00, MUX_STOP=2'b01, MUX_DATA=2'b10, MUX_PAR=2'b11.
- The serializer, tx_parity_calc and the output mux use the same constants.
- No sub-module: the bit counter is a few lines inside the FSM.

Test Plan:
- Reset: assert rst mid-DATA -> same cycle mux_sel=01, ser_en=0, busy=0, data_load=0. After release and no data_valid, the block stays IDLE.
- Single frame, par_en=0:
  - data_valid pulse at cycle 0 -> data_load=1 at cycle 0.
  - Cycle 1 mux_sel=00; cycles 2-9 mux_sel=10 with ser_en=1 (ser_done at cycle 9).
  - Cycle 10 mux_sel=01; cycle 11 IDLE with busy=0. busy high for exactly 10 cycles.
- Single frame, par_en=1: same sequence, plus mux_sel=11 at cycle 10 and stop at cycle 11; busy high 11 cycles. Toggling par_en during DATA does not change this.
- Back-to-back: data_valid held high -> second data_load in the STOP cycle, START on the next cycle, mux_sel never shows idle between frames.
- Timeout: ser_done held 0 -> DATA lasts exactly 8 cycles, frame_err pulses once, then STOP and IDLE.
- data_valid pulsed during START, DATA and PARITY -> no data_load, frame unchanged, no extra frame sent.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: controller states and the
// output-mux select encoding used by the controller, serializer and output mux.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, data, optional parity and stop
// phases, and steers the serializer, parity-calc load and output mux.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       par_en,
  input  logic       ser_done,
  output logic       data_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(data_width) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(data_width - 1);

  state_t           state;
  logic             par_en_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             last_bit;
  logic             timeout;

  // Reset forces IDLE, so the accept strobe is masked while rst is high to
  // keep data_load quiet during reset.
  assign accept    = data_valid && !rst && (state == IDLE || state == STOP);
  assign data_load = accept;
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign timeout   = last_bit && !ser_done;

  // NOTE: every register here is assigned with <= so all state and the
  // registered outputs update together from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mux_sel   <= MUX_STOP;
      ser_en    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      par_en_q  <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            state    <= START;
            mux_sel  <= MUX_START;
            busy     <= 1'b1;
            par_en_q <= par_en;
          end else begin
            state    <= IDLE;
            mux_sel  <= MUX_STOP;
            busy     <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          mux_sel <= MUX_DATA;
          ser_en  <= 1'b1;
          bit_cnt <= '0;
        end
        DATA: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          // A missing ser_done on the last bit slot ends the phase anyway.
          if (ser_done || last_bit) begin
            ser_en    <= 1'b0;
            frame_err <= timeout;
            if (par_en_q) begin
              state   <= PARITY;
              mux_sel <= MUX_PAR;
            end else begin
              state   <= STOP;
              mux_sel <= MUX_STOP;
            end
          end
        end
        PARITY: begin
          state   <= STOP;
          mux_sel <= MUX_STOP;
        end
        default: begin
          state   <= IDLE;
          mux_sel <= MUX_STOP;
          ser_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
